// File: rtl/common_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | common_pkg                                                           |
// | Shared types and constants for the instruction loader.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package common_pkg;

    localparam int LOADER_LEN_BYTES = 4;

    // S_CHK keeps its code even when the checksum build option is off
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_word_assembler                                                |
// | Packs a little-endian byte stream into 32-bit words.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loader_word_assembler
    import common_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_done
);

    localparam logic [1:0] c_LAST_LANE = 2'(LOADER_LEN_BYTES - 1);

    logic [1:0]  r_lane;
    logic [31:0] r_word;

    // Current byte is merged combinationally so the owner can capture the
    // complete word on the same edge that accepts the 4th byte.
    always_comb begin
        word_out = r_word;
        if (byte_valid) begin
            case (r_lane)
                2'd0:    word_out[7:0]   = byte_in;
                2'd1:    word_out[15:8]  = byte_in;
                2'd2:    word_out[23:16] = byte_in;
                default: word_out[31:24] = byte_in;
            endcase
        end
    end

    assign word_done = byte_valid && (r_lane == c_LAST_LANE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
        end else begin
            if (byte_valid) begin
                r_word <= word_out;
            end
            if (clear) begin
                r_lane <= 2'd0;
            end else if (byte_valid) begin
                r_lane <= r_lane + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_instr_loader                                                    |
// | Length-prefixed UART program loader driving the imem write port.     |
// | Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_instr_loader
    import common_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] write_byte_address,
    output logic [31:0] write_instr_data,
    output logic        write_instr_valid,
    output logic        start,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] c_MAX_WORDS   = 32'(MAX_WORDS);
    localparam logic [15:0] c_MAX_LOADED  = 16'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t c_PAYLOAD_END = S_CHK;
`else
    localparam loader_state_t c_PAYLOAD_END = S_DONE;
`endif

    loader_state_t r_state;
    logic [31:0]   r_word_count;
    logic [15:0]   r_words_loaded;
    logic [31:0]   r_write_byte_address;
    logic [31:0]   r_write_instr_data;
    logic          r_write_instr_valid;
    logic          r_start;
    logic          r_load_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_xor;
`endif

    logic          w_asm_valid;
    logic          w_word_done;
    logic [31:0]   w_word;
    logic [31:0]   w_next_loaded;
    logic          w_last;
    logic          w_clear;

    assign w_asm_valid   = rx_valid && ((r_state == S_LEN) || (r_state == S_DATA));
    assign w_next_loaded = {16'd0, r_words_loaded} + 32'd1;
    assign w_last        = (w_next_loaded == r_word_count);
    assign w_clear       = w_word_done &&
                           ((r_state == S_LEN) || ((r_state == S_DATA) && w_last));

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .byte_in    (rx_data),
        .byte_valid (w_asm_valid),
        .word_out   (w_word),
        .word_done  (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state              <= S_LEN;
            r_word_count         <= 32'd0;
            r_words_loaded       <= 16'd0;
            r_write_byte_address <= 32'd0;
            r_write_instr_data   <= 32'd0;
            r_write_instr_valid  <= 1'b0;
            r_start              <= 1'b0;
            r_load_error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor                <= 8'd0;
`endif
        end else begin
            r_write_instr_valid <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_word_done) begin
                        r_word_count <= w_word;
                        if (w_word == 32'd0) begin
                            r_state <= c_PAYLOAD_END;
                            // An empty program has no final strobe to wait behind
                            r_start <= (c_PAYLOAD_END == S_DONE);
                        end else if (w_word > c_MAX_WORDS) begin
                            r_state      <= S_ERR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        r_xor <= r_xor ^ rx_data;
                    end
`endif
                    if (w_word_done) begin
                        r_write_instr_data   <= w_word;
                        r_write_byte_address <= {14'd0, r_words_loaded, 2'b00};
                        r_write_instr_valid  <= 1'b1;
                        if (r_words_loaded != c_MAX_LOADED) begin
                            r_words_loaded <= r_words_loaded + 16'd1;
                        end
                        if (w_last) begin
                            r_state <= c_PAYLOAD_END;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == r_xor) begin
                            r_state <= S_DONE;
                            r_start <= 1'b1;
                        end else begin
                            r_state      <= S_ERR;
                            r_load_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // Raised one cycle after entry so it never overlaps the last strobe
                    r_start <= 1'b1;
                end
                S_ERR: begin
                    r_load_error <= 1'b1;
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign write_byte_address = r_write_byte_address;
    assign write_instr_data   = r_write_instr_data;
    assign write_instr_valid  = r_write_instr_valid;
    assign start              = r_start;
    assign load_error         = r_load_error;
    assign words_loaded       = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_uart_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_instr_loader                                                 |
// | Scoreboard bench for the UART instruction loader.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_instr_loader;

    localparam int MAX_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] write_byte_address;
    logic [31:0] write_instr_data;
    logic        write_instr_valid;
    logic        start;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  tb_xor;
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    uart_instr_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .write_byte_address (write_byte_address),
        .write_instr_data   (write_instr_data),
        .write_instr_valid  (write_instr_valid),
        .start              (start),
        .load_error         (load_error),
        .words_loaded       (words_loaded)
    );

    // Every write strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && write_instr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe addr=%h data=%h required=no strobe",
                         write_byte_address, write_instr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({write_byte_address, write_instr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe addr/data=%h/%h required=%h/%h",
                             write_byte_address, write_instr_data,
                             mon_exp[63:32], mon_exp[31:0]);
                end
            end
            checks++;
            if (start !== 1'b0) begin
                errors++;
                $display("FAIL start_with_strobe start=%b required=0", start);
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        tb_xor   = 8'h00;
        tx_q.delete();
    endtask

    task automatic add_len(input logic [31:0] n);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[23:16]);
        tx_q.push_back(n[31:24]);
    endtask

    task automatic add_word(input logic [31:0] addr, input logic [31:0] w, input bit expect_it);
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(w[8*i +: 8]);
            tb_xor = tb_xor ^ w[8*i +: 8];
        end
        if (expect_it) exp_q.push_back({addr, w});
    endtask

    task automatic send(input int gap);
        while (tx_q.size() > 0) begin
            rx_data  = tx_q.pop_front();
            rx_valid = 1'b1;
            @(negedge clk);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_scoreboard_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_strobes=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({write_byte_address, write_instr_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr_data got=%h/%h required=0/0", write_byte_address, write_instr_data);
        end
        checks++;
        if ({write_instr_valid, start, load_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags valid/start/err=%b%b%b required=000",
                     write_instr_valid, start, load_error);
        end
        checks++;
        if (words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL reset_words_loaded got=%0d required=0", words_loaded);
        end
    endtask

    task automatic test_two_words();
        do_reset();
        add_len(32'd2);
        add_word(32'd0, 32'h0000_0013, 1'b1);
        add_word(32'd4, 32'h0010_0093, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(tb_xor);
`endif
        send(0);
`ifndef LOADER_CHECKSUM_EN
        checks++;
        if ({write_instr_valid, start} !== 2'b10) begin
            errors++;
            $display("FAIL two_words_last_strobe valid/start=%b%b required=10", write_instr_valid, start);
        end
        @(negedge clk);
`endif
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL two_words_start got=%b required=1", start);
        end
        checks++;
        if (words_loaded !== 16'd2) begin
            errors++;
            $display("FAIL two_words_count got=%0d required=2", words_loaded);
        end
        check_scoreboard_empty("two_words_strobes");
        add_word(32'd8, 32'h1234_5678, 1'b0);
        send(0);
        repeat (3) @(negedge clk);
        checks++;
        if ({start, load_error, words_loaded} !== {1'b1, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL done_ignores_input start/err/count=%b/%b/%0d required=1/0/2",
                     start, load_error, words_loaded);
        end
        checks++;
        if ({write_byte_address, write_instr_data} !== {32'd4, 32'h0010_0093}) begin
            errors++;
            $display("FAIL done_holds_outputs got=%h/%h required=4/00100093",
                     write_byte_address, write_instr_data);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        add_len(32'd0);
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(8'h00);
`endif
        send(0);
        checks++;
        if ({start, load_error, words_loaded} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL zero_len start/err/count=%b/%b/%0d required=1/0/0",
                     start, load_error, words_loaded);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        add_len(32'(MAX_WORDS + 1));
        send(0);
        checks++;
        if ({load_error, start} !== 2'b10) begin
            errors++;
            $display("FAIL overflow_err err/start=%b%b required=10", load_error, start);
        end
        add_word(32'd0, 32'hCAFE_F00D, 1'b0);
        add_word(32'd4, 32'h0BAD_F00D, 1'b0);
        send(0);
        repeat (3) @(negedge clk);
        checks++;
        if ({load_error, start, words_loaded} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL overflow_hold err/start/count=%b/%b/%0d required=1/0/0",
                     load_error, start, words_loaded);
        end
    endtask

    task automatic test_gaps();
        int gaps[2] = '{0, 50};
        foreach (gaps[g]) begin
            do_reset();
            add_len(32'd1);
            add_word(32'd0, 32'h1122_3344, 1'b1);
`ifdef LOADER_CHECKSUM_EN
            tx_q.push_back(tb_xor);
`endif
            send(gaps[g]);
            repeat (2) @(negedge clk);
            checks++;
            if ({start, words_loaded} !== {1'b1, 16'd1}) begin
                errors++;
                $display("FAIL gap%0d start/count=%b/%0d required=1/1", gaps[g], start, words_loaded);
            end
            check_scoreboard_empty("gap_strobes");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_len(32'd1);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        send(0);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        tb_xor = 8'h00;
        checks++;
        if ({write_instr_valid, words_loaded} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_clear valid/count=%b/%0d required=0/0", write_instr_valid, words_loaded);
        end
        add_len(32'd1);
        add_word(32'd0, 32'hDEAD_BEEF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(tb_xor);
`endif
        send(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({start, words_loaded} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL reset_mid_reload start/count=%b/%0d required=1/1", start, words_loaded);
        end
        check_scoreboard_empty("reset_mid_strobes");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] sums[2] = '{8'h22, 8'h23};
        foreach (sums[k]) begin
            do_reset();
            add_len(32'd1);
            add_word(32'd0, 32'hDEAD_BEEF, 1'b1);
            tx_q.push_back(sums[k]);
            send(0);
            checks++;
            if ({start, load_error} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL checksum_%h start/err=%b%b required=%s",
                         sums[k], start, load_error, (k == 0) ? "10" : "01");
            end
            check_scoreboard_empty("checksum_strobes");
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tb_xor   = 8'h00;
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_gaps();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        check_scoreboard_empty("final_strobes");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
